// File: rtl/button_debouncer.sv
// Per-button debounce and event detector. A 1 ms square wave (tick_clk) is edge-detected
// into a one-cycle tick; on each tick every synchronized button input advances its own
// four-state qualification FSM, producing a clean level plus press/release/hold pulses.
module button_debouncer #(
  parameter int unsigned NUM_BTN      = 4,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned CNT_W        = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               tick_clk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               tick,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_hold
);

  typedef enum logic [1:0] {
    StReleased,
    StPressPend,
    StPressed,
    StReleasePend
  } state_e;

  // Limits carry one extra bit so cnt + 1 never wraps before the compare.
  localparam logic [CNT_W:0]   StableLim  = (CNT_W+1)'(STABLE_TICKS);
  localparam logic [CNT_W:0]   HoldLim    = (CNT_W+1)'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam bit               FastStable = (STABLE_TICKS == 1);

  logic               r_tick_q;
  logic               r_tick;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;

  state_e             r_state    [NUM_BTN];
  logic [CNT_W-1:0]   r_cnt      [NUM_BTN];
  logic [CNT_W-1:0]   r_hold_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_fired;
  logic [NUM_BTN-1:0] r_level;
  logic [NUM_BTN-1:0] r_press;
  logic [NUM_BTN-1:0] r_release;
  logic [NUM_BTN-1:0] r_hold;

  logic [CNT_W:0]     w_cnt_inc  [NUM_BTN];
  logic [CNT_W:0]     w_hold_inc [NUM_BTN];

  // Rising-edge detect of tick_clk; a held-high tick_clk yields a single tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_q <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_tick_q <= tick_clk;
      r_tick   <= tick_clk & ~r_tick_q;
    end
  end

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Widened increments used for the limit compares.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      w_cnt_inc[i]  = '0;
      w_hold_inc[i] = '0;
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      w_cnt_inc[i]  = {1'b0, r_cnt[i]} + (CNT_W+1)'(1);
      w_hold_inc[i] = {1'b0, r_hold_cnt[i]} + (CNT_W+1)'(1);
    end
  end

  // Per-button qualification FSMs; all state advances only on tick cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_state[i]    <= StReleased;
        r_cnt[i]      <= '0;
        r_hold_cnt[i] <= '0;
      end
      r_fired   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_hold    <= '0;
    end else begin
      r_press   <= '0;
      r_release <= '0;
      r_hold    <= '0;
      if (r_tick) begin
        for (int i = 0; i < NUM_BTN; i++) begin
          unique case (r_state[i])
            StReleased: begin
              if (r_sync2[i]) begin
                if (FastStable) begin
                  r_state[i]    <= StPressed;
                  r_level[i]    <= 1'b1;
                  r_press[i]    <= 1'b1;
                  r_hold_cnt[i] <= '0;
                  r_fired[i]    <= 1'b0;
                end else begin
                  r_state[i] <= StPressPend;
                  r_cnt[i]   <= CntOne;
                end
              end
            end
            StPressPend: begin
              if (!r_sync2[i]) begin
                r_state[i] <= StReleased;
                r_cnt[i]   <= '0;
              end else if (w_cnt_inc[i] == StableLim) begin
                r_state[i]    <= StPressed;
                r_cnt[i]      <= '0;
                r_level[i]    <= 1'b1;
                r_press[i]    <= 1'b1;
                r_hold_cnt[i] <= '0;
                r_fired[i]    <= 1'b0;
              end else begin
                r_cnt[i] <= w_cnt_inc[i][CNT_W-1:0];
              end
            end
            StPressed: begin
              if (!r_sync2[i]) begin
                if (FastStable) begin
                  r_state[i]   <= StReleased;
                  r_level[i]   <= 1'b0;
                  r_release[i] <= 1'b1;
                end else begin
                  r_state[i] <= StReleasePend;
                  r_cnt[i]   <= CntOne;
                end
              end else begin
                if (r_hold_cnt[i] != CntMax) begin
                  r_hold_cnt[i] <= w_hold_inc[i][CNT_W-1:0];
                end
                if ((w_hold_inc[i] == HoldLim) && !r_fired[i]) begin
                  r_hold[i]  <= 1'b1;
                  r_fired[i] <= 1'b1;
                end
              end
            end
            StReleasePend: begin
              // A bounce back high resumes the same press: hold_cnt and fired are kept.
              if (r_sync2[i]) begin
                r_state[i] <= StPressed;
                r_cnt[i]   <= '0;
              end else if (w_cnt_inc[i] == StableLim) begin
                r_state[i]   <= StReleased;
                r_cnt[i]     <= '0;
                r_level[i]   <= 1'b0;
                r_release[i] <= 1'b1;
              end else begin
                r_cnt[i] <= w_cnt_inc[i][CNT_W-1:0];
              end
            end
          endcase
        end
      end
    end
  end

  assign tick        = r_tick;
  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;
  assign btn_hold    = r_hold;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed stimulus pushes expected events (kind, button,
// deciding tick number) into a queue; a monitor pops and compares on every output pulse.
module tb_button_debouncer;

  localparam int unsigned NumBtn = 4;

  logic              clock;
  logic              reset_n;
  logic              tick_clk;
  logic [NumBtn-1:0] btn_raw;
  logic              tick;
  logic [NumBtn-1:0] btn_level;
  logic [NumBtn-1:0] btn_press;
  logic [NumBtn-1:0] btn_release;
  logic [NumBtn-1:0] btn_hold;

  typedef struct packed {
    logic [1:0]  kind;  // 0 press, 1 release, 2 hold
    logic [1:0]  btn;
    logic [27:0] tk;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  int unsigned g_ticks  = 0;
  bit          tick_free = 1'b1;
  int          phase;

  button_debouncer #(
    .NUM_BTN      (NumBtn),
    .STABLE_TICKS (3),
    .HOLD_TICKS   (5),
    .CNT_W        (10)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick_clk    (tick_clk),
    .btn_raw     (btn_raw),
    .tick        (tick),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // 20-cycle tick_clk (10 high, 10 low); forced high while tick_free is cleared.
  initial begin
    phase    = 0;
    tick_clk = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (!tick_free) begin
        tick_clk = 1'b1;
        phase    = 10;
      end else begin
        phase    = (phase + 1) % 20;
        tick_clk = (phase < 10);
      end
    end
  end

  // Count of ticks decided so far; event pulses carry the number of their deciding tick.
  always @(posedge clock) begin
    if (tick) g_ticks <= g_ticks + 1;
  end

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int btn, input int unsigned tk);
    ev_t e;
    e.kind = 2'(kind);
    e.btn  = 2'(btn);
    e.tk   = 28'(tk);
    exp_q.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    int unsigned target;
    int          budget;
    target = g_ticks + n;
    budget = 40 * n + 40;
    while (g_ticks < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (g_ticks < target) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_ticks: tick count %0d, required %0d", g_ticks, target);
    end
  endtask

  task automatic wait_tick_clk(input logic lvl);
    int budget;
    budget = 200;
    while (tick_clk !== lvl && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (tick_clk !== lvl) begin
      n_checks++;
      n_fails++;
      $display("FAIL wait_tick_clk: tick_clk %0b, required %0b", tick_clk, lvl);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  initial begin : monitor
    logic [NumBtn-1:0] prev_level;
    logic [NumBtn-1:0] vec;
    ev_t               got;
    ev_t               want;
    prev_level = '0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
        vec = (k == 0) ? btn_press : (k == 1) ? btn_release : btn_hold;
        for (int b = 0; b < NumBtn; b++) begin
          if (vec[b]) begin
            got.kind = 2'(k);
            got.btn  = 2'(b);
            got.tk   = 28'(g_ticks);
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fails++;
              $display("FAIL unexpected_event: kind %0d btn %0d tick %0d, required none",
                       k, b, g_ticks);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                n_fails++;
                $display("FAIL event: got kind %0d btn %0d tick %0d, required kind %0d btn %0d tick %0d",
                         got.kind, got.btn, got.tk, want.kind, want.btn, want.tk);
              end
            end
            if (k < 2) begin
              check("pulse_vs_level", {30'd0, btn_level[b], prev_level[b]},
                    (k == 0) ? 32'd2 : 32'd1);
            end
          end
        end
      end
      prev_level = btn_level;
    end
  end

  initial begin : stimulus
    int unsigned t;
    int          nt;
    reset_n = 1'b0;
    btn_raw = '0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {15'd0, tick, btn_level, btn_press, btn_release, btn_hold}, 0);
    reset_n = 1'b1;
    wait_ticks(5);
    check("idle_level", 32'(btn_level), 0);

    // Clean press and release on button 0.
    t = g_ticks;
    push(0, 0, t + 3);
    push(1, 0, t + 7);
    btn_raw[0] = 1'b1;
    wait_ticks(2);
    check("b0_not_yet", 32'(btn_level), 0);
    wait_ticks(2);
    check("b0_pressed", 32'(btn_level), 32'h1);
    btn_raw[0] = 1'b0;
    wait_ticks(4);
    check("b0_released", 32'(btn_level), 0);

    // Button 1: press bounce, then release glitch mid-hold, then final release.
    t = g_ticks;
    push(0, 1, t + 6);
    push(2, 1, t + 13);
    push(1, 1, t + 17);
    btn_raw[1] = 1'b1;
    wait_ticks(2);
    btn_raw[1] = 1'b0;
    wait_ticks(1);
    btn_raw[1] = 1'b1;
    wait_ticks(2);
    check("b1_bounce_no_press", 32'(btn_level), 0);
    wait_ticks(1);
    check("b1_pressed", 32'(btn_level), 32'h2);
    wait_ticks(3);
    btn_raw[1] = 1'b0;
    wait_ticks(1);
    check("b1_glitch_held", 32'(btn_level), 32'h2);
    btn_raw[1] = 1'b1;
    wait_ticks(4);
    btn_raw[1] = 1'b0;
    wait_ticks(3);
    check("b1_released", 32'(btn_level), 0);
    wait_ticks(2);

    // Long press on button 2 for 12 ticks.
    t = g_ticks;
    push(0, 2, t + 3);
    push(2, 2, t + 8);
    push(1, 2, t + 15);
    btn_raw[2] = 1'b1;
    wait_ticks(12);
    check("b2_still_pressed", 32'(btn_level), 32'h4);
    btn_raw[2] = 1'b0;
    wait_ticks(3);
    check("b2_released", 32'(btn_level), 0);
    wait_ticks(1);

    // tick_clk held high for 100 cycles: one tick only, button 3 stalls mid-qualification.
    t = g_ticks;
    push(0, 3, t + 3);
    btn_raw[3] = 1'b1;
    wait_tick_clk(1'b0);
    tick_free = 1'b0;
    nt = 0;
    repeat (100) begin
      @(negedge clock);
      if (tick) nt++;
    end
    check("held_tick_clk_ticks", 32'(nt), 1);
    check("held_tick_clk_no_press", 32'(btn_level), 0);
    tick_free = 1'b1;
    wait_ticks(2);
    check("b3_pressed", 32'(btn_level), 32'h8);

    // Reset while button 3 is held; it must re-qualify from scratch.
    wait_ticks(1);
    reset_n = 1'b0;
    #1;
    check("midreset_outputs", {15'd0, tick, btn_level, btn_press, btn_release, btn_hold}, 0);
    wait_tick_clk(1'b1);
    wait_tick_clk(1'b0);
    reset_n = 1'b1;
    t = g_ticks;
    push(0, 3, t + 3);
    push(1, 3, t + 6);
    wait_ticks(2);
    check("b3_requalifying", 32'(btn_level), 0);
    wait_ticks(1);
    check("b3_repressed", 32'(btn_level), 32'h8);
    btn_raw[3] = 1'b0;
    wait_ticks(3);
    check("b3_released", 32'(btn_level), 0);

    wait_ticks(3);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
